alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-add multiplier controller for the EXE stage. It computes the ARM MUL result (low 32 bits of Rm*Rs) by sequencing the existing single-cycle ALU through repeated ADD commands.
- It owns the ALU's Val1/Val2/EXE_CMD inputs while busy and captures the ALU's Result each cycle.
- The pipeline stalls on busy. Result and status are delivered with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width.
- ADD_CMD, 4'b0010, ALU EXE_CMD for ADD.
- NOP_CMD, 4'b0000, ALU EXE_CMD driven when idle or skipping an add (ALU default, result 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request multiply; sampled only in IDLE.
- flush  in  1  synchronous abort from hazard/branch unit.
- op_a  in  WIDTH  multiplicand (Rm).
- op_b  in  WIDTH  multiplier (Rs).
- S  in  1  update-status request from the instruction.
- SR  in  4  current status register {N,Z,C,V}.
- ALU_Val1  out  WIDTH  to ALU Val1.
- ALU_Val2  out  WIDTH  to ALU Val2.
- ALU_EXE_CMD  out  4  to ALU EXE_CMD.
- ALU_Result  in  WIDTH  from ALU Result (combinational, same cycle).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, result valid.
- Result  out  WIDTH  product, held until next start.
- Status  out  4  {N,Z,C,V} for the product.
- status_we  out  1  equals S latched at start, qualified by done.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; acc, mcand, mplier, count, Result = 0.
  - Status=4'b0000, done=0, busy=0, status_we=0.
  - ALU_EXE_CMD=NOP_CMD, ALU_Val1=ALU_Val2=0.
- IDLE:
  - start=1 latches mcand=op_a, mplier=op_b, s_q=S, and clears acc and count.
  - Next state is RUN if op_b!=0, else DONE.
  - start=0 keeps the block in IDLE.
- RUN (one cycle per multiplier bit):
  - ALU_Val1=acc, ALU_Val2=mcand.
  - ALU_EXE_CMD = mplier[0] ? ADD_CMD : NOP_CMD.
  - At the clock edge: if mplier[0], acc<=ALU_Result (32-bit wrap, carry discarded); mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - Go to DONE when (mplier>>1)==0 or count==WIDTH-1; otherwise stay in RUN.
- DONE (exactly one cycle):
  - done=1, Result=acc.
  - Status={acc[31], acc==0, SR[1], SR[0]}: C and V pass through unchanged, per ARM MUL.
  - status_we=s_q. Next state is IDLE.
- Outside DONE: done=0 and status_we=0. Result/Status hold their last DONE value.
- Latency: let n = floor(log2(op_b))+1 for op_b!=0, and n=0 for op_b=0. With start sampled at edge 0, RUN occupies cycles 1..n and done is high in cycle n+1. Maximum is 33 cycles.
- start asserted while busy is ignored (no queuing). start asserted in the DONE cycle is also ignored.
- flush=1 in RUN or DONE:
  - Go to IDLE at the next edge; suppress done and status_we.
  - Result/Status keep their previous values.
  - flush has priority over start and over state transitions. flush in IDLE with start=1 also blocks the start.
- Reset mid-operation returns immediately to reset values; no done is produced.
- ALU outputs are NOP_CMD with zero operands in IDLE and DONE, so the ALU's internal flag registers see only ADD traffic.

Test Plan:
- op_a=3, op_b=5, S=1, SR=4'b0011 -> ADD issued in RUN cycles 1 and 3, NOP in cycle 2; done in cycle 4; Result=15; Status=4'b0011; status_we=1.
- op_a=0x1234, op_b=0 -> no RUN cycles; done in cycle 1; Result=0; Status Z=1, N=0, C/V copied from SR.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, S=0 -> 32 RUN cycles; done in cycle 33; Result=0x00000001; status_we=0.
- op_a=0xFFFFFFFF, op_b=2 -> done in cycle 3; Result=0xFFFFFFFE; N=1, Z=0.
- Start a 0xFFFFFFFF*0x80000000 multiply and assert flush in RUN cycle 10 -> IDLE next cycle; no done pulse; Result unchanged. A start asserted in cycle 5 of that run is ignored.
- Drive rst=0 asynchronously in RUN cycle 7 -> outputs take reset values immediately. After release, 7*6 completes with Result=42 and done in cycle 4.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer for the EXE stage: drives the shared ALU with
// ADD/NOP commands, one multiplier bit per cycle, and delivers the low WIDTH bits of op_a*op_b.
module alu_mul_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [3:0]  ADD_CMD = 4'b0010,
  parameter logic [3:0]  NOP_CMD = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             S,
  input  logic [3:0]       SR,
  output logic [WIDTH-1:0] ALU_Val1,
  output logic [WIDTH-1:0] ALU_Val2,
  output logic [3:0]       ALU_EXE_CMD,
  input  logic [WIDTH-1:0] ALU_Result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Status,
  output logic             status_we
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             s_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_sh;
  logic             run_last;

  always_comb begin
    acc_nxt   = mplier[0] ? ALU_Result : acc;
    mplier_sh = mplier >> 1;
    run_last  = (mplier_sh == '0) || (count == CW'(WIDTH - 1));
  end

  // The ALU only ever sees operands while running, so its flag logic observes ADD traffic alone.
  always_comb begin
    ALU_Val1    = '0;
    ALU_Val2    = '0;
    ALU_EXE_CMD = NOP_CMD;
    if (state == RUN) begin
      ALU_Val1    = acc;
      ALU_Val2    = mcand;
      ALU_EXE_CMD = mplier[0] ? ADD_CMD : NOP_CMD;
    end
  end

  assign busy = (state != IDLE);

  // done/Result/Status are loaded on the edge entering DONE so they are valid throughout that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      s_q       <= 1'b0;
      done      <= 1'b0;
      status_we <= 1'b0;
      Result    <= '0;
      Status    <= 4'b0000;
    end else begin
      done      <= 1'b0;
      status_we <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mcand  <= op_a;
              mplier <= op_b;
              s_q    <= S;
              acc    <= '0;
              count  <= '0;
              if (op_b != '0) begin
                state <= RUN;
              end else begin
                state     <= DONE;
                done      <= 1'b1;
                status_we <= S;
                Result    <= '0;
                Status    <= {1'b0, 1'b1, SR[1:0]};
              end
            end
          end
          RUN: begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_sh;
            count  <= count + 1'b1;
            if (run_last) begin
              state     <= DONE;
              done      <= 1'b1;
              status_we <= s_q;
              Result    <= acc_nxt;
              Status    <= {acc_nxt[WIDTH-1], acc_nxt == '0, SR[1:0]};
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: behavioural ALU plus a plain-arithmetic
// reference for product, latency, status and per-cycle ADD/NOP issue.
module tb_alu_mul_sequencer;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] NOP = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        S;
  logic [3:0]  SR;
  logic [31:0] ALU_Val1;
  logic [31:0] ALU_Val2;
  logic [3:0]  ALU_EXE_CMD;
  logic [31:0] ALU_Result;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic [3:0]  Status;
  logic        status_we;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_result = '0;
  logic [3:0]  last_status = '0;

  always #5 clk = ~clk;

  // Single-cycle ALU: ADD sums, anything else yields zero.
  always_comb ALU_Result = (ALU_EXE_CMD == ADD) ? ALU_Val1 + ALU_Val2 : 32'd0;

  alu_mul_sequencer #(.WIDTH(32), .ADD_CMD(ADD), .NOP_CMD(NOP)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .S(S), .SR(SR),
    .ALU_Val1(ALU_Val1), .ALU_Val2(ALU_Val2), .ALU_EXE_CMD(ALU_EXE_CMD),
    .ALU_Result(ALU_Result), .busy(busy), .done(done),
    .Result(Result), .Status(Status), .status_we(status_we)
  );

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0; S = 1'b0; SR = '0;
    #13;
    total++;
    if ({busy, done, status_we} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000", {busy, done, status_we});
    end
    total++;
    if ({Result, Status} !== 36'd0) begin
      bad++; $display("FAIL reset_result got=%h/%b want=0/0000", Result, Status);
    end
    total++;
    if ({ALU_EXE_CMD, ALU_Val1, ALU_Val2} !== {NOP, 64'd0}) begin
      bad++; $display("FAIL reset_alu got=%b/%h/%h want=NOP/0/0", ALU_EXE_CMD, ALU_Val1, ALU_Val2);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input logic [3:0] sr);
    logic [31:0] p;
    logic [3:0]  exp_status;
    logic [3:0]  exp_cmd;
    int n;
    int lat;
    p = a * b;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    exp_status = {p[31], p == 32'd0, sr[1:0]};
    op_a = a; op_b = b; S = s; SR = sr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin lat = k; break; end
      if (k <= n) begin
        exp_cmd = b[k-1] ? ADD : NOP;
        total++;
        if (ALU_EXE_CMD !== exp_cmd || busy !== 1'b1) begin
          bad++; $display("FAIL run_cmd a=%h b=%h cyc=%0d got=%b busy=%b want=%b busy=1",
                          a, b, k, ALU_EXE_CMD, busy, exp_cmd);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (lat != n + 1) begin
      bad++; $display("FAIL latency a=%h b=%h got=%0d want=%0d", a, b, lat, n + 1);
    end
    if (lat != 0) begin
      total++;
      if (Result !== p) begin
        bad++; $display("FAIL result a=%h b=%h got=%h want=%h", a, b, Result, p);
      end
      total++;
      if (Status !== exp_status || status_we !== s) begin
        bad++; $display("FAIL status a=%h b=%h got=%b we=%b want=%b we=%b",
                        a, b, Status, status_we, exp_status, s);
      end
      total++;
      if ({busy, ALU_EXE_CMD, ALU_Val1, ALU_Val2} !== {1'b1, NOP, 64'd0}) begin
        bad++; $display("FAIL done_alu got=%b/%b/%h/%h want=1/NOP/0/0",
                        busy, ALU_EXE_CMD, ALU_Val1, ALU_Val2);
      end
      @(posedge clk); #1;
      total++;
      if ({done, busy, status_we} !== 3'b000 || Result !== p) begin
        bad++; $display("FAIL after_done got=%b res=%h want=000 res=%h",
                        {done, busy, status_we}, Result, p);
      end
    end
    last_result = p;
    last_status = exp_status;
  endtask

  task automatic test_directed();
    test_mul_op(32'd3, 32'd5, 1'b1, 4'b0011);
    test_mul_op(32'h1234, 32'd0, 1'b1, 4'b0110);
    test_mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'b1010);
    test_mul_op(32'hFFFF_FFFF, 32'd2, 1'b1, 4'b0001);
  endtask

  task automatic test_flush();
    op_a = 32'hFFFF_FFFF; op_b = 32'h8000_0000; S = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL flush_run cyc=%0d done=%b busy=%b want done=0 busy=1", k, done, busy);
      end
      if (k == 5) begin start = 1'b1; op_a = 32'd1; op_b = 32'd1; end
      if (k == 6) start = 1'b0;
      if (k == 10) flush = 1'b1;
      if (k < 10) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if ({busy, done, status_we} !== 3'b000 || Result !== last_result || Status !== last_status) begin
      bad++; $display("FAIL flush_idle got=%b res=%h st=%b want=000 res=%h st=%b",
                      {busy, done, status_we}, Result, Status, last_result, last_status);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL flush_quiet cyc=%0d done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    // flush in IDLE blocks a simultaneous start
    start = 1'b1; flush = 1'b1; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL flush_blocks_start busy=%b want=0", busy);
    end
  endtask

  task automatic test_start_in_done();
    int seen;
    op_a = 32'd2; op_b = 32'd3; S = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      if (done) begin
        seen = k;
        start = 1'b1; op_b = 32'd5;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (seen != 3 || busy !== 1'b0 || Result !== 32'd6) begin
      bad++; $display("FAIL start_in_done done_cyc=%0d busy=%b res=%h want 3 0 6", seen, busy, Result);
    end
    last_result = 32'd6;
    last_status = {1'b0, 1'b0, SR[1:0]};
  endtask

  task automatic test_reset_mid();
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; S = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({busy, done, status_we} !== 3'b000 || Result !== '0 || Status !== '0 ||
        ALU_EXE_CMD !== NOP || ALU_Val1 !== '0 || ALU_Val2 !== '0) begin
      bad++; $display("FAIL reset_mid got=%b res=%h st=%b cmd=%b v1=%h want all zero/NOP",
                      {busy, done, status_we}, Result, Status, ALU_EXE_CMD, ALU_Val1);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL reset_no_done cyc=%0d done=%b want=0", k, done);
      end
    end
    test_mul_op(32'd7, 32'd6, 1'b1, 4'b0000);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b = $urandom >> $urandom_range(0, 32);
      test_mul_op(a, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_start_in_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
